cache_refill_controller: RTL

- Consumes the victim-line choice from the cache's replacement logic and carries out the eviction.
- If the victim is valid and dirty, writes it back to memory word by word. It then fetches the missing line from memory and writes it into the chosen way.
- Commits the tag/valid bits, then tells the replacement logic the way was written so recency can update.
- Sits between the cache hit/miss datapath and the memory-side request/ready port.

---
 rtl/cache_refill_pkg.sv | 39 +++
 rtl/refill_beat_counter.sv | 37 +++
 rtl/cache_refill_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cache_refill_pkg.sv
// Shared widths, FSM state type and address-field helpers for the cache refill controller.
// Optional feature macro: CACHE_CRITICAL_WORD_FIRST_EN.
package cache_refill_pkg;

    localparam int SET_SIZE    = 4;
    localparam int SEL_WIDTH   = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int LINE_WORDS  = 4;
    localparam int OFF_WIDTH   = $clog2(LINE_WORDS);
    localparam int INDEX_WIDTH = 4;
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFF_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1 -: TAG_WIDTH];
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return a[INDEX_WIDTH+OFF_WIDTH+1 -: INDEX_WIDTH];
    endfunction

    function automatic logic [OFF_WIDTH-1:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
        return a[OFF_WIDTH+1 -: OFF_WIDTH];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] build_addr(input logic [TAG_WIDTH-1:0]   tag,
                                                         input logic [INDEX_WIDTH-1:0] idx,
                                                         input logic [OFF_WIDTH-1:0]   off);
        return {tag, idx, off, 2'b00};
    endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// Word-offset counter for refill bursts: loads a start offset, advances per beat with
// natural wrap, and flags the beat that returns to the start offset (the last of the line).
module refill_beat_counter
    import cache_refill_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [OFF_WIDTH-1:0] start_i,
    input  logic                 en_i,
    output logic [OFF_WIDTH-1:0] cnt_o,
    output logic                 last_o
);

    logic [OFF_WIDTH-1:0] r_cnt;
    logic [OFF_WIDTH-1:0] r_start;
    logic [OFF_WIDTH-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + OFF_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_start <= '0;
        end else if (load_i) begin
            r_cnt   <= start_i;
            r_start <= start_i;
        end else if (en_i) begin
            r_cnt   <= w_cnt_inc;
        end
    end

    // After LINE_WORDS beats the counter is back at its start offset.
    assign cnt_o  = r_cnt;
    assign last_o = (w_cnt_inc == r_start);

endmodule

// File: rtl/cache_refill_controller.sv
// Victim write-back and line fill sequencer between the cache datapath and memory.
// Define CACHE_CRITICAL_WORD_FIRST_EN to fill from the requested word first and expose crit_valid_o.
module cache_refill_controller
    import cache_refill_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   miss_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [SEL_WIDTH-1:0]   victim_i,
    input  logic                   victim_valid_i,
    input  logic                   victim_dirty_i,
    input  logic [TAG_WIDTH-1:0]   victim_tag_i,
    input  logic [DATA_WIDTH-1:0]  line_rdata_i,
    output logic [OFF_WIDTH-1:0]   line_raddr_o,
    output logic                   line_we_o,
    output logic [SEL_WIDTH-1:0]   line_sel_o,
    output logic [OFF_WIDTH-1:0]   line_waddr_o,
    output logic [DATA_WIDTH-1:0]  line_wdata_o,
    output logic                   tag_we_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0]  mem_wdata_o,
    input  logic                   mem_ready_i,
    input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
    output logic                   repl_write_en_o,
    output logic                   busy_o,
    output logic                   done_o,
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    output logic                   crit_valid_o,
`endif
    output state_t                 state_o
);

    // Memory handshake: a beat completes in any cycle where mem_req_o and mem_ready_i are both 1;
    // the request holds address/data steady until then, and ready without a request is ignored.

    state_t                   r_state;
    state_t                   w_next;
    logic [TAG_WIDTH-1:0]     r_miss_tag;
    logic [INDEX_WIDTH-1:0]   r_index;
    logic [SEL_WIDTH-1:0]     r_victim;
    logic [TAG_WIDTH-1:0]     r_victim_tag;
    logic                     w_beat;
    logic                     w_load;
    logic [OFF_WIDTH-1:0]     w_load_off;
    logic [OFF_WIDTH-1:0]     w_cnt;
    logic                     w_last;
    logic [OFF_WIDTH-1:0]     w_miss_start;
    logic [OFF_WIDTH-1:0]     w_fill_start;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic [OFF_WIDTH-1:0]     r_crit_off;

    assign w_miss_start = addr_offset(addr_i);
    assign w_fill_start = r_crit_off;
    assign crit_valid_o = (r_state == FILL) && w_beat && (w_cnt == r_crit_off);
`else
    assign w_miss_start = '0;
    assign w_fill_start = '0;
`endif

    assign w_beat     = ((r_state == WB) || (r_state == FILL)) && mem_ready_i;
    assign busy_o     = (r_state != IDLE);
    assign line_sel_o = busy_o ? r_victim : '0;
    assign state_o    = r_state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_miss_tag   <= '0;
            r_index      <= '0;
            r_victim     <= '0;
            r_victim_tag <= '0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            r_crit_off   <= '0;
`endif
        end else if ((r_state == IDLE) && miss_i) begin
            r_miss_tag   <= addr_tag(addr_i);
            r_index      <= addr_index(addr_i);
            r_victim     <= victim_i;
            r_victim_tag <= victim_tag_i;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            r_crit_off   <= addr_offset(addr_i);
`endif
        end
    end

    refill_beat_counter u_beat_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (w_load),
        .start_i (w_load_off),
        .en_i    (w_beat),
        .cnt_o   (w_cnt),
        .last_o  (w_last)
    );

    always_comb begin
        w_next          = r_state;
        w_load          = 1'b0;
        w_load_off      = '0;
        line_raddr_o    = '0;
        line_we_o       = 1'b0;
        line_waddr_o    = '0;
        line_wdata_o    = '0;
        tag_we_o        = 1'b0;
        tag_o           = '0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        repl_write_en_o = 1'b0;
        done_o          = 1'b0;
        case (r_state)
            IDLE: begin
                if (miss_i) begin
                    w_load = 1'b1;
                    if (victim_valid_i && victim_dirty_i) begin
                        w_next     = WB;
                        w_load_off = '0;
                    end else begin
                        w_next     = FILL;
                        w_load_off = w_miss_start;
                    end
                end
            end
            WB: begin
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_addr_o   = build_addr(r_victim_tag, r_index, w_cnt);
                line_raddr_o = w_cnt;
                mem_wdata_o  = line_rdata_i;
                // Reload the counter so the fill can begin at its own start offset.
                if (w_beat && w_last) begin
                    w_next     = FILL;
                    w_load     = 1'b1;
                    w_load_off = w_fill_start;
                end
            end
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = build_addr(r_miss_tag, r_index, w_cnt);
                if (w_beat) begin
                    line_we_o    = 1'b1;
                    line_waddr_o = w_cnt;
                    line_wdata_o = mem_rdata_i;
                    if (w_last) begin
                        w_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                tag_we_o        = 1'b1;
                tag_o           = r_miss_tag;
                repl_write_en_o = 1'b1;
                done_o          = 1'b1;
                w_next          = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
